// File: rtl/triple_buffer_pkg.sv
// triple_buffer_pkg: bank index width and reset bank assignment for the triple buffer
package triple_buffer_pkg;
    localparam int BANK_W = 2;
    localparam logic [BANK_W-1:0] WR_BANK_RST = 2'd0;
    localparam logic [BANK_W-1:0] SPARE_RST   = 2'd1;
    localparam logic [BANK_W-1:0] RD_BANK_RST = 2'd2;
endpackage

// File: rtl/triple_buffer_ctrl_if.sv
// triple_buffer_ctrl_if: writer/reader handshake and bank/address bus; drop_count exists only with TB_DROP_CNT_EN
interface triple_buffer_ctrl_if #(parameter int ADDR_W = 8);
    import triple_buffer_pkg::*;
    logic              wr_en;
    logic              wr_commit;
    logic              rd_req;
    logic              rd_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_full;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_len;
    logic              rd_grant;
    logic              fresh;
`ifdef TB_DROP_CNT_EN
    logic [15:0]       drop_count;
`endif
    modport master (
        output wr_en, wr_commit, rd_req, rd_en,
        input  wr_bank, wr_addr, wr_full, rd_bank, rd_addr, rd_len, rd_grant, fresh
`ifdef TB_DROP_CNT_EN
        , input drop_count
`endif
    );
    modport slave (
        input  wr_en, wr_commit, rd_req, rd_en,
        output wr_bank, wr_addr, wr_full, rd_bank, rd_addr, rd_len, rd_grant, fresh
`ifdef TB_DROP_CNT_EN
        , output drop_count
`endif
    );
endinterface

// File: rtl/tb_addr_counter.sv
// tb_addr_counter: word address counter with sync clear over enable and wrap at a runtime limit
module tb_addr_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [width-1:0] wrap_at,
    output logic [width-1:0] count
);
    // clear wins, otherwise step and wrap back to zero at wrap_at
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= (count == wrap_at) ? '0 : count + 1'b1;
endmodule

// File: rtl/triple_buffer_ctrl.sv
// triple_buffer_ctrl: bank rotation and address sequencing for the UART triple buffer; TB_DROP_CNT_EN adds drop_count
module triple_buffer_ctrl
    import triple_buffer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input logic           clk,
    input logic           reset,
    triple_buffer_ctrl_if.slave bus
);
    logic [BANK_W-1:0] spare;
    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   fresh_len;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              commit;
    logic              grant_go;

    // a word written alongside the commit belongs to the committed frame
    assign eff_len  = {1'b0, bus.wr_addr} + (ADDR_W+1)'(bus.wr_en);
    assign commit   = (bus.wr_commit && eff_len != '0) || (bus.wr_en && bus.wr_addr == ADDR_W'(DEPTH-1));
    assign grant_go = bus.rd_req && (commit || bus.fresh);
    assign bus.wr_full = 1'b0;
    assign bus.wr_addr = wr_addr;
    assign bus.rd_addr = rd_addr;

    // bank ownership rotation and frame bookkeeping
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.wr_bank  <= WR_BANK_RST;
            spare        <= SPARE_RST;
            bus.rd_bank  <= RD_BANK_RST;
            bus.rd_len   <= '0;
            fresh_len    <= '0;
            bus.fresh    <= 1'b0;
            bus.rd_grant <= 1'b0;
        end else begin
            bus.rd_grant <= grant_go;
            if (commit && bus.rd_req) begin
                bus.rd_bank <= bus.wr_bank;
                bus.wr_bank <= spare;
                spare       <= bus.rd_bank;
                bus.rd_len  <= eff_len;
                bus.fresh   <= 1'b0;
            end else if (commit) begin
                spare       <= bus.wr_bank;
                bus.wr_bank <= spare;
                fresh_len   <= eff_len;
                bus.fresh   <= 1'b1;
            end else if (grant_go) begin
                bus.rd_bank <= spare;
                spare       <= bus.rd_bank;
                bus.rd_len  <= fresh_len;
                bus.fresh   <= 1'b0;
            end
        end

    tb_addr_counter #(.width(ADDR_W)) u_wr_cnt (
        .clk(clk), .reset(reset), .en(bus.wr_en), .clr(commit),
        .wrap_at(ADDR_W'(DEPTH-1)), .count(wr_addr)
    );

    tb_addr_counter #(.width(ADDR_W)) u_rd_cnt (
        .clk(clk), .reset(reset), .en(bus.rd_en && bus.rd_len != '0), .clr(grant_go),
        .wrap_at(ADDR_W'(bus.rd_len - 1'b1)), .count(rd_addr)
    );

`ifdef TB_DROP_CNT_EN
    // count fresh frames overwritten before the reader claimed them
    always_ff @(posedge clk or negedge reset)
        if (!reset) bus.drop_count <= '0;
        else if (commit && bus.fresh && !bus.rd_req && bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 1'b1;
`endif
endmodule

// File: tb/tb_triple_buffer_ctrl.sv
// tb_triple_buffer_ctrl: vector table, corner sequences and randomized model check for triple_buffer_ctrl
module tb_triple_buffer_ctrl;
    localparam int AW = 2;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    triple_buffer_ctrl_if #(.ADDR_W(AW)) bus ();

    triple_buffer_ctrl #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    typedef struct {
        int we, wc, rq, re;
        int wb, wa, rb, ra, rl, g, f;
    } vec_t;

    vec_t tbl[24];

    int own[3];
    int m_wa, m_ra, m_rl, m_fl, m_fr, m_g, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int wb, wa, rb, ra, rl, g, f);
        chk({tag, " wr_bank"},  32'(bus.wr_bank),  wb);
        chk({tag, " wr_addr"},  32'(bus.wr_addr),  wa);
        chk({tag, " rd_bank"},  32'(bus.rd_bank),  rb);
        chk({tag, " rd_addr"},  32'(bus.rd_addr),  ra);
        chk({tag, " rd_len"},   32'(bus.rd_len),   rl);
        chk({tag, " rd_grant"}, 32'(bus.rd_grant), g);
        chk({tag, " fresh"},    32'(bus.fresh),    f);
        chk({tag, " wr_full"},  32'(bus.wr_full),  0);
    endtask

    task automatic drive(input bit we, wc, rq, re);
        bus.wr_en = we;
        bus.wr_commit = wc;
        bus.rd_req = rq;
        bus.rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_en = 0; bus.wr_commit = 0; bus.rd_req = 0; bus.rd_en = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic model_reset();
        own = '{0, 1, 2};
        m_wa = 0; m_ra = 0; m_rl = 0; m_fl = 0; m_fr = 0; m_g = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit we, wc, rq, re);
        int len, t[3];
        bit cm, take;
        len = m_wa + int'(we);
        cm = (wc && len > 0) || (we && m_wa == DP-1);
        take = rq && (cm || m_fr != 0);
        if (take) m_ra = 0;
        else if (re && m_rl > 0) m_ra = (m_ra + 1) % m_rl;
        m_wa = cm ? 0 : m_wa + int'(we);
        t = own;
        if (cm && rq) begin
            own = '{t[1], t[2], t[0]};
            m_rl = len;
            m_fr = 0;
        end else if (cm) begin
            if (m_fr != 0 && m_drop < 65535) m_drop++;
            own = '{t[1], t[0], t[2]};
            m_fl = len;
            m_fr = 1;
        end else if (take) begin
            own = '{t[0], t[2], t[1]};
            m_rl = m_fl;
            m_fr = 0;
        end
        m_g = int'(take);
    endtask

    initial begin
        tbl = '{
            '{1,0,0,0, 0,1,2,0,0,0,0},
            '{1,0,0,0, 0,2,2,0,0,0,0},
            '{1,0,0,0, 0,3,2,0,0,0,0},
            '{0,1,0,0, 1,0,2,0,0,0,1},
            '{0,0,1,0, 1,0,0,0,3,1,0},
            '{0,0,0,1, 1,0,0,1,3,0,0},
            '{0,0,0,1, 1,0,0,2,3,0,0},
            '{0,0,0,1, 1,0,0,0,3,0,0},
            '{0,0,0,1, 1,0,0,1,3,0,0},
            '{1,0,0,0, 1,1,0,1,3,0,0},
            '{1,0,0,0, 1,2,0,1,3,0,0},
            '{1,0,0,0, 1,3,0,1,3,0,0},
            '{1,0,0,0, 2,0,0,1,3,0,1},
            '{0,0,1,0, 2,0,1,0,4,1,0},
            '{1,0,0,0, 2,1,1,0,4,0,0},
            '{1,1,0,0, 0,0,1,0,4,0,1},
            '{1,0,0,0, 0,1,1,0,4,0,1},
            '{1,0,0,0, 0,2,1,0,4,0,1},
            '{1,1,0,0, 2,0,1,0,4,0,1},
            '{0,0,1,0, 2,0,0,0,3,1,0},
            '{0,1,0,0, 2,0,0,0,3,0,0},
            '{0,0,1,0, 2,0,0,0,3,0,0},
            '{0,0,0,1, 2,0,0,1,3,0,0},
            '{1,0,0,1, 2,1,0,2,3,0,0}
        };

        bus.wr_en = 0; bus.wr_commit = 0; bus.rd_req = 0; bus.rd_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 2, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].we != 0, tbl[i].wc != 0, tbl[i].rq != 0, tbl[i].re != 0);
            chk_all($sformatf("vec%0d", i), tbl[i].wb, tbl[i].wa, tbl[i].rb, tbl[i].ra, tbl[i].rl, tbl[i].g, tbl[i].f);
        end
`ifdef TB_DROP_CNT_EN
        chk("drop_count after table", 32'(bus.drop_count), 1);
`endif

        do_reset();
        drive(0, 0, 0, 1);
        chk("rd_en with rd_len 0", 32'(bus.rd_addr), 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 0);
        chk_all("simul", 1, 0, 0, 0, 2, 1, 0);
        drive(0, 0, 0, 0);
        chk("simul grant drop", 32'(bus.rd_grant), 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk_all("spare was 2", 2, 0, 0, 0, 2, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("midframe wr_addr", 32'(bus.wr_addr), 2);
        reset = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 2, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 0, 1, 0);
        chk_all("req after reset", 0, 0, 2, 0, 0, 0, 0);

        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bit we, wc, rq, re;
            we = $urandom_range(0, 3) != 0;
            wc = $urandom_range(0, 5) == 0;
            rq = $urandom_range(0, 4) == 0;
            re = $urandom_range(0, 1) != 0;
            model_step(we, wc, rq, re);
            drive(we, wc, rq, re);
            chk_all($sformatf("rand%0d", n), own[0], m_wa, own[2], m_ra, m_rl, m_g, m_fr);
`ifdef TB_DROP_CNT_EN
            chk($sformatf("rand%0d drop_count", n), 32'(bus.drop_count), m_drop);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
